// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
// Holds the select width, FSM state encoding and the wrap-around step helper.
package mux_seq_pkg;

    localparam int SEL_W = 2;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] SEL_FIRST = '0;
    localparam logic [SEL_W-1:0] SEL_LAST  = '1;
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

    // One advance of the select bus: up wraps LAST->FIRST, down wraps FIRST->LAST.
    function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] cur,
                                                     input logic             down);
        logic [SEL_W-1:0] nxt;
        if (down) begin
            nxt = (cur == SEL_FIRST) ? SEL_LAST : cur - SEL_ONE;
        end else begin
            nxt = (cur == SEL_LAST) ? SEL_FIRST : cur + SEL_ONE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_rate_divider.sv
// Down-counting rate divider: zero is high in the last cycle of each TICK_DIV-cycle period.
// clr reloads the count and wins over en; the count holds while en is low.
module rate_divider #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic zero
);

    localparam int               CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - ONE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for a two-level 4:1 mux: auto-advances every TICK_DIV cycles while
// running, single-steps on step rising edges while paused, and can be loaded directly.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             run,
    input  logic             dir,
    input  logic             step,
    input  logic             load,
    input  logic [SEL_W-1:0] load_sel,
    output logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic             running
);

    // Handshake-free block: all inputs are sampled levels on every CLOCK_50 edge;
    // tick is a one-cycle strobe marking the first cycle of each new sel value.

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             tick_q, tick_d;
    logic             step_prev_q, step_prev_d;
    logic             armed_q, armed_d;

    logic div_en;
    logic div_clr;
    logic div_zero;
    logic step_rise;
    logic advance;

    rate_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (div_en),
        .clr      (div_clr),
        .zero     (div_zero)
    );

    always_comb begin
        state_d     = run ? RUNNING : PAUSED;
        step_prev_d = step;
        // armed_q stays low for the first cycle after reset so a step held through
        // release is not mistaken for a fresh rising edge.
        armed_d     = 1'b1;
        step_rise   = step & ~step_prev_q & armed_q;

        div_en  = (state_q == RUNNING);
        div_clr = load | ((state_q == PAUSED) & run);
        advance = (state_q == RUNNING) ? div_zero : step_rise;

        sel_d  = sel_q;
        tick_d = 1'b0;
        if (load) begin
            sel_d = load_sel;
        end else if (advance) begin
            sel_d  = sel_advance(sel_q, dir);
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= PAUSED;
            sel_q       <= SEL_FIRST;
            tick_q      <= 1'b0;
            step_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tick_q      <= tick_d;
            step_prev_q <= step_prev_d;
            armed_q     <= armed_d;
        end
    end

    assign sel     = sel_q;
    assign tick    = tick_q;
    assign running = (state_q == RUNNING);

endmodule
